// File: rtl/pu_ext_int_ctrl_pkg.sv
// pu_ext_int_ctrl_pkg: shared types for the external-input / doorbell
// interrupt source. Holds the Int_ctrl_reg layout, the default pin
// synchronizer depth and the doorbell FSM state encoding.
`timescale 1ns/1ps

package pu_ext_int_ctrl_pkg;

  // Width of each per-pin field inside Int_ctrl_reg; NUM_GIN must match it.
  localparam int GIN_FIELD_W = 4;

  // Default number of flops in each general-input synchronizer.
  localparam int GIN_SYNC_STAGES = 2;

  // Int_ctrl_reg layout, LSB first:
  //   [3:0]   gin_sense_level  1 = level sensitive, 0 = edge sensitive
  //   [7:4]   gin_trigger      0 = high / rising, 1 = low / falling
  //   [11:8]  gin_mask         1 = pin may raise ext_input
  //   [12]    doorbell_en      1 = doorbell messages accepted
  //   [31:13] reserved
  typedef struct packed {
    logic [18:0]            reserved;
    logic                   doorbell_en;
    logic [GIN_FIELD_W-1:0] gin_mask;
    logic [GIN_FIELD_W-1:0] gin_trigger;
    logic [GIN_FIELD_W-1:0] gin_sense_level;
  } int_ctrl_reg_t;

  // Doorbell request state: idle, or a doorbell waiting for the core.
  typedef enum logic {
    DB_IDLE = 1'b0,
    DB_PEND = 1'b1
  } doorbell_state_t;

endpackage

// File: rtl/pu_ext_int_ctrl_sync_chain.sv
// pu_sync_chain: multi-bit flop-chain synchronizer for asynchronous pins.
// Each bit is synchronized independently; DEPTH must be at least 2.
// Reset is synchronous and active low.
`timescale 1ns/1ps

module pu_sync_chain #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift the raw pin values through DEPTH flops; clear the whole chain on reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage[k] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int k = 1; k < DEPTH; k++) begin
        stage[k] <= stage[k-1];
      end
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/pu_ext_int_ctrl.sv
// pu_ext_int_ctrl: source of the ext_input and doorbell exception requests.
// Synchronizes the general-input pins, applies per-pin sense, polarity and
// mask from Int_ctrl_reg, keeps the software-visible pending register, and
// runs the doorbell request FSM.
// Optional build macro PU_INT_CTRL_CAUSE_EN adds the 'cause' output giving
// the lowest-index unmasked pending pin.
`timescale 1ns/1ps

module pu_ext_int_ctrl
  import pu_ext_int_ctrl_pkg::*;
#(
  parameter int NUM_GIN     = 4,
  parameter int SYNC_STAGES = GIN_SYNC_STAGES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_GIN-1:0] gin,
  input  logic [31:0]        ctrl,
  input  logic               pend_clr_we,
  input  logic [NUM_GIN-1:0] pend_clr,
  input  logic               doorbell_set,
  input  logic               doorbell_ack,
  output logic [NUM_GIN-1:0] pending,
  output logic               ext_input,
  output logic               doorbell
`ifdef PU_INT_CTRL_CAUSE_EN
  ,
  output logic [$clog2(NUM_GIN)-1:0] cause
`endif
);

  // Startup guard: edges are ignored until the synchronizer and prev have
  // both been refilled after reset, so a pin already high does not fire.
  localparam int GUARD_MAX = SYNC_STAGES + 1;
  localparam int CNT_W     = $clog2(GUARD_MAX + 1);

  int_ctrl_reg_t        cfg;
  logic [NUM_GIN-1:0]   sense_level;
  logic [NUM_GIN-1:0]   trigger;
  logic [NUM_GIN-1:0]   mask;
  logic                 db_en;
  logic                 unused_ctrl_bits;

  logic [NUM_GIN-1:0]   gin_s;
  logic [NUM_GIN-1:0]   prev;
  logic [CNT_W-1:0]     guard_cnt;
  logic                 edge_en;

  logic [NUM_GIN-1:0]   act;
  logic [NUM_GIN-1:0]   edge_set;
  logic [NUM_GIN-1:0]   clr_mask;
  logic [NUM_GIN-1:0]   pending_nxt;
  logic [NUM_GIN-1:0]   unmasked;

  doorbell_state_t      db_state;

  assign cfg         = int_ctrl_reg_t'(ctrl);
  assign sense_level = cfg.gin_sense_level[NUM_GIN-1:0];
  assign trigger     = cfg.gin_trigger[NUM_GIN-1:0];
  assign mask        = cfg.gin_mask[NUM_GIN-1:0];
  assign db_en       = cfg.doorbell_en;

  assign unused_ctrl_bits = ^cfg.reserved;

  pu_sync_chain #(
    .WIDTH (NUM_GIN),
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (gin),
    .q     (gin_s)
  );

  // Previous synchronized pin value, used for raw change detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev <= '0;
    end else begin
      prev <= gin_s;
    end
  end

  // Startup counter: counts up after reset and saturates to enable edges.
  always_ff @(posedge clk) begin
    if (!reset) begin
      guard_cnt <= '0;
    end else if (!edge_en) begin
      guard_cnt <= guard_cnt + 1'b1;
    end
  end

  assign edge_en = (guard_cnt == CNT_W'(GUARD_MAX));

  // Edges come from raw s/prev so rewriting gin_trigger cannot fake one;
  // polarity only decides whether the change is the interesting direction.
  assign act      = gin_s ^ trigger;
  assign edge_set = {NUM_GIN{edge_en}} & (gin_s ^ prev) & act;
  assign clr_mask = pend_clr_we ? pend_clr : '0;
  assign unmasked = pending & mask;

  // Next pending value: level pins follow act, edge pins are sticky with set winning over clear.
  always_comb begin
    pending_nxt = '0;
    for (int i = 0; i < NUM_GIN; i++) begin
      if (sense_level[i]) begin
        pending_nxt[i] = act[i];
      end else begin
        pending_nxt[i] = edge_set[i] | (pending[i] & ~clr_mask[i]);
      end
    end
  end

  // Pending register and the ext_input request derived from unmasked pending bits.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pending   <= '0;
      ext_input <= 1'b0;
    end else begin
      pending   <= pending_nxt;
      ext_input <= |unmasked;
    end
  end

`ifdef PU_INT_CTRL_CAUSE_EN
  localparam int CAUSE_W = $clog2(NUM_GIN);

  logic [CAUSE_W-1:0] cause_nxt;

  // Priority encoder: lowest-index unmasked pending pin.
  always_comb begin
    cause_nxt = '0;
    for (int i = NUM_GIN - 1; i >= 0; i--) begin
      if (unmasked[i]) begin
        cause_nxt = CAUSE_W'(i);
      end
    end
  end

  // Cause follows ext_input timing and holds its last value while idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cause <= '0;
    end else if (|unmasked) begin
      cause <= cause_nxt;
    end
  end
`endif

  // Doorbell FSM: one outstanding doorbell; extra strobes are absorbed,
  // and disabling doorbells drops a waiting request.
  always_ff @(posedge clk) begin
    if (!reset) begin
      db_state <= DB_IDLE;
      doorbell <= 1'b0;
    end else begin
      case (db_state)
        DB_IDLE: begin
          if (doorbell_set && db_en) begin
            db_state <= DB_PEND;
            doorbell <= 1'b1;
          end
        end
        DB_PEND: begin
          if (!db_en || (doorbell_ack && !doorbell_set)) begin
            db_state <= DB_IDLE;
            doorbell <= 1'b0;
          end
        end
        default: begin
          db_state <= DB_IDLE;
          doorbell <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pu_ext_int_ctrl.md
Name: pu_ext_int_ctrl

Overview:
Source side of the core's external-input and doorbell exception signals. The block samples the 4 general-input pins (gin), applies per-pin sense, polarity and mask, and keeps a pending register. It drives the ext_input and doorbell fields of the base exception struct towards the processing unit's exception logic. Configuration comes from the interrupt controller control register (Int_ctrl_reg); the core clears pending state through write-1-to-clear strobes and a doorbell acknowledge.

Parameters:
NUM_GIN, 4, number of general-input pins; must match the width of the Int_ctrl_reg gin fields.
SYNC_STAGES, 2, flip-flop stages in each pin synchronizer; minimum 2.

Ports:
clk  in  1  core clock.
reset  in  1  synchronous reset, active low; one clock domain.
gin  in  NUM_GIN  asynchronous general-input pins.
ctrl  in  32  Int_ctrl_reg; fields gin_sense_level, gin_trigger, gin_mask, doorbell_en.
pend_clr_we  in  1  strobe; clears pending bits selected by pend_clr.
pend_clr  in  NUM_GIN  write-1-to-clear mask, qualified by pend_clr_we.
doorbell_set  in  1  one-cycle doorbell message strobe.
doorbell_ack  in  1  core has taken the doorbell interrupt.
pending  out  NUM_GIN  pending status, readable by software.
ext_input  out  1  external-input exception request (Except_base.ext_input).
doorbell  out  1  doorbell exception request (Except_base.doorbell).

Behaviour:
- Reset (reset==0 at a clk edge): synchronizers, prev, pending, ext_input, doorbell and startup counter all go to 0.
- Synchronizer: gin[i] passes through SYNC_STAGES flops to give s[i]. prev[i] registers s[i] every cycle.
- Startup guard:
  - Counter runs 0..SYNC_STAGES+1 after reset, then saturates.
  - Edge detection is disabled until the counter saturates. This prevents a spurious edge on a pin that is already high at reset.
  - Level mode is not gated.
- Active value per pin: act[i] = s[i] XOR gin_trigger[i]. gin_trigger 0 means high level or rising edge; 1 means low level or falling edge.
- Edge mode (gin_sense_level[i]==0):
  - Set pending[i] when the raw value changes: (s[i]!=prev[i]) and act[i]==1.
  - Edges are computed from raw s/prev, so rewriting gin_trigger never creates an edge.
  - Sticky; cleared only by pend_clr.
- Level mode (gin_sense_level[i]==1):
  - pending[i] is registered act[i], one cycle after s[i].
  - pend_clr has no effect on the bit.
- Simultaneous set and clear on the same pin in the same cycle: set wins.
- Mask: gin_mask[i] gates only ext_input, never pending. Unmasking a pending pin raises ext_input one cycle later.
- ext_input is registered: OR over all pins of (pending & gin_mask). It stays asserted while any unmasked bit is pending; the core masks via MSR.
- Latency from a gin change meeting setup at edge 0:
  - s changes at edge SYNC_STAGES-1.
  - pending changes at edge SYNC_STAGES.
  - ext_input changes at edge SYNC_STAGES+1 (default: 3 cycles).
- Doorbell FSM:
  - IDLE: doorbell_set && doorbell_en moves to PEND.
  - PEND: doorbell=1; doorbell_ack moves to IDLE. Further doorbell_set strobes are absorbed (not counted).
  - set and ack in the same cycle in PEND: stay in PEND.
  - doorbell_en falling while in PEND moves to IDLE.
  - doorbell output is registered from the state (doorbell = state==PEND).
- Changing gin_sense_level from edge to level: pending[i] tracks the level from the next cycle on. Changing from level to edge: pending[i] holds its value until cleared.

Optional Feature:
PU_INT_CTRL_CAUSE_EN:
- Defined: adds output cause (width $clog2(NUM_GIN)). It holds the lowest-index pin with pending & gin_mask set, is registered in the same cycle as ext_input, and holds its last value when ext_input==0.
- Undefined: the port and its logic are absent.

Decomposition:
- Pu_interrupt package:
  - keeps Int_ctrl_reg;
  - adds constant GIN_SYNC_STAGES = 2;
  - adds enum Doorbell_state {DB_IDLE, DB_PEND}.
- One sub-module, pu_sync_chain: parameterised width and depth, synchronous active-low reset. It is instantiated once, NUM_GIN wide.

Test Plan:
- Reset value: hold gin=4'b0001 high through reset; set ctrl to edge mode, trigger 0, mask 4'hF; release reset -> pending stays 0 and ext_input stays 0 for 20 cycles (startup guard).
- Rising edge: gin[2] 0->1 at edge 0 -> pending=4'b0100 at edge 2 and ext_input=1 at edge 3. Then pend_clr_we=1 with pend_clr=4'b0100 -> pending=0, and ext_input=0 one cycle later.
- Level and falling polarity: gin[1] level mode, trigger 1. Drive gin[1]=0 -> pending[1]=1. Drive gin[1]=1 -> pending[1]=0 after the same latency. pend_clr on pin 1 has no effect while the level is held.
- Masking and set/clear collision: with gin_mask=0, an edge on gin[3] sets pending[3] but ext_input stays 0; setting mask bit 3 -> ext_input=1 next cycle. Separately, an edge arriving in the same cycle as pend_clr on that pin -> bit remains 1.
- Doorbell: doorbell_set with doorbell_en=0 -> doorbell stays 0. With doorbell_en=1 -> doorbell=1 next cycle. A second set, then ack -> doorbell=0 and no second request. set and ack in the same cycle while pending -> doorbell stays 1.
- Reset mid-operation: with pending=4'hF and doorbell=1, assert reset for one cycle -> all outputs 0 on the next edge. The startup guard re-arms.
